prt_dp_app_ram_arb: RTL and testbench

//  Two-master arbiter feeding one RAM slave over prt_dp_app_ram_if. Sits directly upstream of the application RAM.

---
 rtl/prt_dp_app_ram_arb_pkg.sv | 13 +
 rtl/prt_dp_app_ram_if.sv | 19 +
 rtl/prt_dp_app_ram_arb_rr.sv | 21 ++
 rtl/prt_dp_app_ram_arb.sv | 170 +++++++++++++++++
 tb/tb_prt_dp_app_ram_arb.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/prt_dp_app_ram_arb_pkg.sv
// Shared types and constants for the two-master application RAM arbiter.
package prt_dp_app_ram_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, ACK} arb_sta_t;
  typedef logic arb_gnt_t;

  localparam arb_gnt_t P_GNT_M0 = 1'b0;
  localparam arb_gnt_t P_GNT_M1 = 1'b1;

  localparam int P_DAT_WIDTH = 32;
  localparam int P_MSK_WIDTH = P_DAT_WIDTH / 8;

endpackage

// File: rtl/prt_dp_app_ram_if.sv
// Application RAM bus: the mst side drives request fields and write data (dout), the slv side answers.
interface prt_dp_app_ram_if
  import prt_dp_app_ram_arb_pkg::*;
#(
  parameter int P_ADR_WIDTH = 16
);

  logic [P_ADR_WIDTH-1:0] adr;
  logic                   wr;
  logic [P_MSK_WIDTH-1:0] msk;
  logic [P_DAT_WIDTH-1:0] din;
  logic [P_DAT_WIDTH-1:0] dout;
  logic                   req;
  logic                   ack;

  modport mst (output adr, wr, msk, dout, req, input din, ack);
  modport slv (input adr, wr, msk, din, req, output dout, ack);

endinterface

// File: rtl/prt_dp_app_ram_arb_rr.sv
// Combinational two-way round-robin pick: a tie goes to the master that did not own the last transaction.
module prt_dp_app_ram_arb_rr
  import prt_dp_app_ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_gnt_t   last_i,
  output arb_gnt_t   gnt_o,
  output logic       vld_o
);

  always_comb begin
    vld_o = |req_i;
    gnt_o = P_GNT_M0;
    if (req_i == 2'b11) begin
      gnt_o = ~last_i;
    end else if (req_i[1]) begin
      gnt_o = P_GNT_M1;
    end
  end

endmodule

// File: rtl/prt_dp_app_ram_arb.sv
// Two-master round-robin arbiter in front of the application RAM, one transaction in flight.
// Define PRT_DP_APP_RAM_ARB_TIMEOUT_EN to add the slave-ack watchdog that answers with P_TIMEOUT_DAT.
module prt_dp_app_ram_arb
  import prt_dp_app_ram_arb_pkg::*;
#(
  parameter int                     P_ADR_WIDTH   = 16,
  parameter int                     P_TIMEOUT     = 1024,
  parameter logic [P_DAT_WIDTH-1:0] P_TIMEOUT_DAT = 32'hDEADBEEF
) (
  input  logic          CLK_IN,
  input  logic          RST_IN,
  prt_dp_app_ram_if.slv M0_IF,
  prt_dp_app_ram_if.slv M1_IF,
  prt_dp_app_ram_if.mst RAM_IF,
  output logic          GNT_OUT,
  output logic          TO_OUT
);

  arb_sta_t               sta_q, sta_d;
  arb_gnt_t               gnt_q, gnt_d;
  logic                   ramReq_q, ramReq_d;
  logic                   ramWr_q, ramWr_d;
  logic [P_MSK_WIDTH-1:0] ramMsk_q, ramMsk_d;
  logic [P_ADR_WIDTH-1:0] ramAdr_q, ramAdr_d;
  logic [P_DAT_WIDTH-1:0] ramDat_q, ramDat_d;
  logic                   m0Ack_q, m0Ack_d;
  logic                   m1Ack_q, m1Ack_d;
  logic [P_DAT_WIDTH-1:0] m0Dat_q, m0Dat_d;
  logic [P_DAT_WIDTH-1:0] m1Dat_q, m1Dat_d;
  logic                   to_q, to_d;

  arb_gnt_t               rrGnt;
  logic                   rrVld;
  logic                   toExp;
  logic [P_DAT_WIDTH-1:0] rtnDat;

  prt_dp_app_ram_arb_rr rrArb (
    .req_i  ({M1_IF.req, M0_IF.req}),
    .last_i (gnt_q),
    .gnt_o  (rrGnt),
    .vld_o  (rrVld)
  );

`ifdef PRT_DP_APP_RAM_ARB_TIMEOUT_EN
  localparam int P_CNT_W = $clog2(P_TIMEOUT);

  logic [P_CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside REQ so every transaction starts its wait count fresh.
  always_comb begin
    cnt_d = '0;
    if (sta_q == REQ) cnt_d = cnt_q + P_CNT_W'(1);
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign toExp = (sta_q == REQ) && (cnt_q == P_CNT_W'(P_TIMEOUT - 1));
`else
  logic unusedTimeout;

  assign unusedTimeout = (P_TIMEOUT > 1);
  assign toExp         = 1'b0;
`endif

  // A real slave ack always beats a watchdog expiry in the same cycle.
  assign rtnDat = RAM_IF.ack ? RAM_IF.din : P_TIMEOUT_DAT;

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      sta_q    <= IDLE;
      gnt_q    <= P_GNT_M1;
      ramReq_q <= 1'b0;
      ramWr_q  <= 1'b0;
      ramMsk_q <= '0;
      ramAdr_q <= '0;
      ramDat_q <= '0;
      m0Ack_q  <= 1'b0;
      m1Ack_q  <= 1'b0;
      m0Dat_q  <= '0;
      m1Dat_q  <= '0;
      to_q     <= 1'b0;
    end else begin
      sta_q    <= sta_d;
      gnt_q    <= gnt_d;
      ramReq_q <= ramReq_d;
      ramWr_q  <= ramWr_d;
      ramMsk_q <= ramMsk_d;
      ramAdr_q <= ramAdr_d;
      ramDat_q <= ramDat_d;
      m0Ack_q  <= m0Ack_d;
      m1Ack_q  <= m1Ack_d;
      m0Dat_q  <= m0Dat_d;
      m1Dat_q  <= m1Dat_d;
      to_q     <= to_d;
    end
  end

  // ACK always falls back to IDLE so a req still high in the ack cycle is never taken again.
  always_comb begin
    sta_d = sta_q;
    unique case (sta_q)
      IDLE:    if (rrVld) sta_d = REQ;
      REQ:     if (RAM_IF.ack || toExp) sta_d = ACK;
      default: sta_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = gnt_q;
    ramReq_d = ramReq_q;
    ramWr_d  = ramWr_q;
    ramMsk_d = ramMsk_q;
    ramAdr_d = ramAdr_q;
    ramDat_d = ramDat_q;
    m0Ack_d  = 1'b0;
    m1Ack_d  = 1'b0;
    m0Dat_d  = m0Dat_q;
    m1Dat_d  = m1Dat_q;
    to_d     = 1'b0;
    unique case (sta_q)
      IDLE: begin
        if (rrVld) begin
          gnt_d    = rrGnt;
          ramReq_d = 1'b1;
          if (rrGnt == P_GNT_M1) begin
            ramWr_d  = M1_IF.wr;
            ramMsk_d = M1_IF.msk;
            ramAdr_d = M1_IF.adr;
            ramDat_d = M1_IF.din;
          end else begin
            ramWr_d  = M0_IF.wr;
            ramMsk_d = M0_IF.msk;
            ramAdr_d = M0_IF.adr;
            ramDat_d = M0_IF.din;
          end
        end
      end
      REQ: begin
        if (RAM_IF.ack || toExp) begin
          ramReq_d = 1'b0;
          to_d     = !RAM_IF.ack;
          if (gnt_q == P_GNT_M1) begin
            m1Ack_d = 1'b1;
            m1Dat_d = rtnDat;
          end else begin
            m0Ack_d = 1'b1;
            m0Dat_d = rtnDat;
          end
        end
      end
      default: ;
    endcase
  end

  assign RAM_IF.req  = ramReq_q;
  assign RAM_IF.wr   = ramWr_q;
  assign RAM_IF.msk  = ramMsk_q;
  assign RAM_IF.adr  = ramAdr_q;
  assign RAM_IF.dout = ramDat_q;
  assign M0_IF.ack   = m0Ack_q;
  assign M0_IF.dout  = m0Dat_q;
  assign M1_IF.ack   = m1Ack_q;
  assign M1_IF.dout  = m1Dat_q;
  assign GNT_OUT     = gnt_q;
  assign TO_OUT      = to_q;

endmodule

// File: tb/tb_prt_dp_app_ram_arb.sv
// Directed, table-driven bench for prt_dp_app_ram_arb; watchdog expectations follow PRT_DP_APP_RAM_ARB_TIMEOUT_EN.
module tb_prt_dp_app_ram_arb;

  typedef struct packed {
    logic        wr;
    logic [3:0]  msk;
    logic [15:0] adr;
    logic [31:0] dat;
  } fld_t;

  typedef struct packed {
    logic        rst;
    logic        m0Req;
    fld_t        m0Fld;
    logic        m1Req;
    fld_t        m1Fld;
    logic        ramAck;
    logic [31:0] ramDin;
  } vecIn_t;

  typedef struct packed {
    logic        ramReq;
    fld_t        ramFld;
    logic        m0Ack;
    logic [31:0] m0Dout;
    logic        m1Ack;
    logic [31:0] m1Dout;
    logic        gnt;
    logic        to;
  } vecOut_t;

  typedef struct {
    string   name;
    vecIn_t  in;
    vecOut_t exp;
  } vec_t;

  localparam fld_t Z  = '0;
  localparam fld_t F0 = {1'b1, 4'b0011, 16'h0010, 32'h12345678};
  localparam fld_t F1 = {1'b0, 4'b1111, 16'h0100, 32'h00000000};
  localparam fld_t F2 = {1'b0, 4'b1111, 16'h0200, 32'h00000000};
  localparam fld_t F3 = {1'b0, 4'b1111, 16'h0300, 32'h00000000};
  localparam fld_t F4 = {1'b0, 4'b1100, 16'h0304, 32'h00000000};
  localparam fld_t F5 = {1'b1, 4'b1000, 16'hFFFF, 32'hCAFEF00D};

  logic clk;
  logic rst;
  logic gntOut;
  logic toOut;
  int   checks;
  int   errors;
  vec_t vecs[$];

  prt_dp_app_ram_if #(.P_ADR_WIDTH(16)) m0If ();
  prt_dp_app_ram_if #(.P_ADR_WIDTH(16)) m1If ();
  prt_dp_app_ram_if #(.P_ADR_WIDTH(16)) ramIf ();

  prt_dp_app_ram_arb #(
    .P_ADR_WIDTH   (16),
    .P_TIMEOUT     (8),
    .P_TIMEOUT_DAT (32'hDEADBEEF)
  ) dut (
    .CLK_IN  (clk),
    .RST_IN  (rst),
    .M0_IF   (m0If),
    .M1_IF   (m1If),
    .RAM_IF  (ramIf),
    .GNT_OUT (gntOut),
    .TO_OUT  (toOut)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vecIn_t mkIn(logic r, logic q0, fld_t f0, logic q1, fld_t f1,
                                  logic a, logic [31:0] d);
    return {r, q0, f0, q1, f1, a, d};
  endfunction

  function automatic vecOut_t mkOut(logic rq, fld_t rf, logic a0, logic [31:0] d0,
                                    logic a1, logic [31:0] d1, logic g, logic t);
    return {rq, rf, a0, d0, a1, d1, g, t};
  endfunction

  function automatic string fmtOut(vecOut_t o);
    return $sformatf("req=%0b wr=%0b msk=%h adr=%h wdat=%h ack0=%0b dout0=%h ack1=%0b dout1=%h gnt=%0b to=%0b",
                     o.ramReq, o.ramFld.wr, o.ramFld.msk, o.ramFld.adr, o.ramFld.dat,
                     o.m0Ack, o.m0Dout, o.m1Ack, o.m1Dout, o.gnt, o.to);
  endfunction

  task automatic addVec(string n, vecIn_t i, vecOut_t e);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit after the rising edge.
  task automatic applyStimulus(vecIn_t v);
    @(negedge clk);
    rst        = v.rst;
    m0If.req   = v.m0Req;
    m0If.wr    = v.m0Fld.wr;
    m0If.msk   = v.m0Fld.msk;
    m0If.adr   = v.m0Fld.adr;
    m0If.din   = v.m0Fld.dat;
    m1If.req   = v.m1Req;
    m1If.wr    = v.m1Fld.wr;
    m1If.msk   = v.m1Fld.msk;
    m1If.adr   = v.m1Fld.adr;
    m1If.din   = v.m1Fld.dat;
    ramIf.ack  = v.ramAck;
    ramIf.din  = v.ramDin;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string n, vecOut_t e);
    vecOut_t act;
    act = {ramIf.req, ramIf.wr, ramIf.msk, ramIf.adr, ramIf.dout,
           m0If.ack, m0If.dout, m1If.ack, m1If.dout, gntOut, toOut};
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s: got %s, expected %s", n, fmtOut(act), fmtOut(e));
    end
  endtask

  initial begin
    vecOut_t rstOut;
    vecOut_t expOut;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    {m0If.req, m0If.wr, m0If.msk, m0If.adr, m0If.din} = '0;
    {m1If.req, m1If.wr, m1If.msk, m1If.adr, m1If.din} = '0;
    {ramIf.ack, ramIf.din} = '0;
    rstOut = mkOut(0, Z, 0, 0, 0, 0, 1, 0);

    addVec("reset",           mkIn(1, 0, Z,  0, Z,  0, 0),         rstOut);
    // M0 write, zero-wait RAM
    addVec("t1 ram req",      mkIn(0, 1, F0, 0, Z,  0, 0),         mkOut(1, F0, 0, 32'h00, 0, 0, 0, 0));
    addVec("t1 m0 ack",       mkIn(0, 1, F0, 0, Z,  1, 32'h55),    mkOut(0, F0, 1, 32'h55, 0, 0, 0, 0));
    addVec("t1 ack pulse",    mkIn(0, 1, F0, 0, Z,  0, 0),         mkOut(0, F0, 0, 32'h55, 0, 0, 0, 0));
    addVec("t1 idle",         mkIn(0, 0, Z,  0, Z,  0, 0),         mkOut(0, F0, 0, 32'h55, 0, 0, 0, 0));
    // Simultaneous requests after reset, then alternation
    addVec("t2 reset",        mkIn(1, 0, Z,  0, Z,  0, 0),         rstOut);
    addVec("t2 tie to m0",    mkIn(0, 1, F1, 1, F2, 0, 0),         mkOut(1, F1, 0, 32'h00, 0, 0, 0, 0));
    addVec("t2 m0 ack",       mkIn(0, 1, F1, 1, F2, 1, 32'hA0),    mkOut(0, F1, 1, 32'hA0, 0, 0, 0, 0));
    addVec("t2 m0 ack pulse", mkIn(0, 1, F1, 1, F2, 0, 0),         mkOut(0, F1, 0, 32'hA0, 0, 0, 0, 0));
    addVec("t2 tie to m1",    mkIn(0, 1, F1, 1, F2, 0, 0),         mkOut(1, F2, 0, 32'hA0, 0, 0, 1, 0));
    addVec("t2 m1 ack",       mkIn(0, 1, F1, 1, F2, 1, 32'hB0),    mkOut(0, F2, 0, 32'hA0, 1, 32'hB0, 1, 0));
    addVec("t2 m1 ack pulse", mkIn(0, 1, F1, 1, F2, 0, 0),         mkOut(0, F2, 0, 32'hA0, 0, 32'hB0, 1, 0));
    addVec("t2 m0 pending",   mkIn(0, 1, F1, 0, Z,  0, 0),         mkOut(1, F1, 0, 32'hA0, 0, 32'hB0, 0, 0));
    addVec("t2 m0 ack 2",     mkIn(0, 1, F1, 0, Z,  1, 32'hA4),    mkOut(0, F1, 1, 32'hA4, 0, 32'hB0, 0, 0));
    addVec("t2 ack pulse 2",  mkIn(0, 1, F1, 0, Z,  0, 0),         mkOut(0, F1, 0, 32'hA4, 0, 32'hB0, 0, 0));
    addVec("stray ram ack",   mkIn(0, 0, Z,  0, Z,  1, 32'hFF),    mkOut(0, F1, 0, 32'hA4, 0, 32'hB0, 0, 0));
    // M1 back-to-back, stale req in the ack cycle
    addVec("t3 m1 first",     mkIn(0, 0, Z,  1, F3, 0, 0),         mkOut(1, F3, 0, 32'hA4, 0, 32'hB0, 1, 0));
    addVec("t3 m1 ack 1",     mkIn(0, 0, Z,  1, F3, 1, 32'hC0),    mkOut(0, F3, 0, 32'hA4, 1, 32'hC0, 1, 0));
    addVec("t3 stale req",    mkIn(0, 0, Z,  1, F3, 0, 0),         mkOut(0, F3, 0, 32'hA4, 0, 32'hC0, 1, 0));
    addVec("t3 m1 second",    mkIn(0, 0, Z,  1, F4, 0, 0),         mkOut(1, F4, 0, 32'hA4, 0, 32'hC0, 1, 0));
    addVec("t3 m1 ack 2",     mkIn(0, 0, Z,  1, F4, 1, 32'hC4),    mkOut(0, F4, 0, 32'hA4, 1, 32'hC4, 1, 0));
    addVec("t3 ack pulse",    mkIn(0, 0, Z,  1, F4, 0, 0),         mkOut(0, F4, 0, 32'hA4, 0, 32'hC4, 1, 0));
    addVec("t3 idle",         mkIn(0, 0, Z,  0, Z,  0, 0),         mkOut(0, F4, 0, 32'hA4, 0, 32'hC4, 1, 0));
    // Five wait states; M0 drops req and fields mid-transaction
    addVec("t4 ram req",      mkIn(0, 1, F5, 0, Z,  0, 0),         mkOut(1, F5, 0, 32'hA4, 0, 32'hC4, 0, 0));
    addVec("t4 wait 1",       mkIn(0, 1, F5, 0, Z,  0, 0),         mkOut(1, F5, 0, 32'hA4, 0, 32'hC4, 0, 0));
    addVec("t4 wait 2",       mkIn(0, 1, F5, 0, Z,  0, 0),         mkOut(1, F5, 0, 32'hA4, 0, 32'hC4, 0, 0));
    addVec("t4 wait 3 drop",  mkIn(0, 0, Z,  0, Z,  0, 0),         mkOut(1, F5, 0, 32'hA4, 0, 32'hC4, 0, 0));
    addVec("t4 wait 4",       mkIn(0, 0, Z,  0, Z,  0, 0),         mkOut(1, F5, 0, 32'hA4, 0, 32'hC4, 0, 0));
    addVec("t4 wait 5",       mkIn(0, 0, Z,  0, Z,  0, 0),         mkOut(1, F5, 0, 32'hA4, 0, 32'hC4, 0, 0));
    addVec("t4 m0 ack",       mkIn(0, 0, Z,  0, Z,  1, 32'hD0),    mkOut(0, F5, 1, 32'hD0, 0, 32'hC4, 0, 0));
    addVec("t4 ack pulse",    mkIn(0, 0, Z,  0, Z,  0, 0),         mkOut(0, F5, 0, 32'hD0, 0, 32'hC4, 0, 0));
    // Reset during REQ, coinciding with a RAM ack
    addVec("t5 m1 req",       mkIn(0, 0, Z,  1, F2, 0, 0),         mkOut(1, F2, 0, 32'hD0, 0, 32'hC4, 1, 0));
    addVec("t5 reset in req", mkIn(1, 0, Z,  1, F2, 1, 32'hEE),    rstOut);
    addVec("t5 tie to m0",    mkIn(0, 1, F1, 1, F2, 0, 0),         mkOut(1, F1, 0, 32'h00, 0, 0, 0, 0));
    addVec("t5 m0 ack",       mkIn(0, 1, F1, 1, F2, 1, 32'h11),    mkOut(0, F1, 1, 32'h11, 0, 0, 0, 0));
    addVec("t5 ack pulse",    mkIn(0, 1, F1, 1, F2, 0, 0),         mkOut(0, F1, 0, 32'h11, 0, 0, 0, 0));
    addVec("t5 m1 next",      mkIn(0, 0, Z,  1, F2, 0, 0),         mkOut(1, F2, 0, 32'h11, 0, 0, 1, 0));
    addVec("t5 m1 ack",       mkIn(0, 0, Z,  1, F2, 1, 32'h22),    mkOut(0, F2, 0, 32'h11, 1, 32'h22, 1, 0));
    addVec("t5 ack pulse 2",  mkIn(0, 0, Z,  1, F2, 0, 0),         mkOut(0, F2, 0, 32'h11, 0, 32'h22, 1, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].in);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // RAM never acks: watchdog answers 8 cycles after the RAM request when enabled.
    applyStimulus(mkIn(0, 1, F0, 0, Z, 0, 0));
    checkOutput("t6 ram req", mkOut(1, F0, 0, 32'h11, 0, 32'h22, 0, 0));
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(mkIn(0, 1, F0, 0, Z, 0, 0));
      checkOutput($sformatf("t6 waiting %0d", i), mkOut(1, F0, 0, 32'h11, 0, 32'h22, 0, 0));
    end
    applyStimulus(mkIn(0, 1, F0, 0, Z, 0, 0));
`ifdef PRT_DP_APP_RAM_ARB_TIMEOUT_EN
    expOut = mkOut(0, F0, 1, 32'hDEADBEEF, 0, 32'h22, 0, 1);
`else
    expOut = mkOut(1, F0, 0, 32'h11, 0, 32'h22, 0, 0);
`endif
    checkOutput("t6 expiry", expOut);
    applyStimulus(mkIn(0, 1, F0, 0, Z, 0, 0));
`ifdef PRT_DP_APP_RAM_ARB_TIMEOUT_EN
    expOut = mkOut(0, F0, 0, 32'hDEADBEEF, 0, 32'h22, 0, 0);
`else
    expOut = mkOut(1, F0, 0, 32'h11, 0, 32'h22, 0, 0);
`endif
    checkOutput("t6 after expiry", expOut);
    applyStimulus(mkIn(1, 0, Z, 0, Z, 0, 0));
    checkOutput("t6 reset", rstOut);

    // RAM ack lands in the expiry cycle: real data, no timeout pulse.
    applyStimulus(mkIn(0, 1, F1, 0, Z, 0, 0));
    checkOutput("t7 ram req", mkOut(1, F1, 0, 32'h00, 0, 0, 0, 0));
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(mkIn(0, 1, F1, 0, Z, 0, 0));
      checkOutput($sformatf("t7 waiting %0d", i), mkOut(1, F1, 0, 32'h00, 0, 0, 0, 0));
    end
    applyStimulus(mkIn(0, 1, F1, 0, Z, 1, 32'h77));
    checkOutput("t7 ack at expiry", mkOut(0, F1, 1, 32'h77, 0, 0, 0, 0));
    applyStimulus(mkIn(0, 1, F1, 0, Z, 0, 0));
    checkOutput("t7 ack pulse", mkOut(0, F1, 0, 32'h77, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
